// File: rtl/gpioemu_pkg.sv
// Shared constants and types for the gpioemu result FIFO: register offsets,
// entry layout and status word packing.
package gpioemu_pkg;

  localparam int unsigned OFS_W    = 0;
  localparam int unsigned OFS_L    = 8;
  localparam int unsigned OFS_STAT = 16;

  localparam int unsigned RES_W_BITS = 32;
  localparam int unsigned RES_L_BITS = 24;
  localparam int unsigned ENTRY_W    = 1 + RES_L_BITS + RES_W_BITS;

  localparam int unsigned STAT_FULL_BIT  = 15;
  localparam int unsigned STAT_EMPTY_BIT = 14;
  localparam int unsigned STAT_CNT_W     = 7;

  localparam int unsigned FLUSH_BIT    = 0;
  localparam int unsigned CLR_DROP_BIT = 1;

  typedef struct packed {
    logic                  ovf;
    logic [RES_L_BITS-1:0] l;
    logic [RES_W_BITS-1:0] w;
  } entry_t;

  // Status word: {drop_cnt, 8'b0, full, empty, 7'b0, count}
  function automatic logic [31:0] pack_status(input logic [7:0] drop,
                                              input logic full,
                                              input logic empty,
                                              input logic [STAT_CNT_W-1:0] cnt);
    logic [31:0] s;
    s = '0;
    s[31:24]          = drop;
    s[STAT_FULL_BIT]  = full;
    s[STAT_EMPTY_BIT] = empty;
    s[STAT_CNT_W-1:0] = cnt;
    return s;
  endfunction

endpackage

// File: rtl/gpioemu_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head, flush, and a look-ahead
// empty flag so the owner can register a pending indication without extra lag.
module gpioemu_sync_fifo
  import gpioemu_pkg::*;
#(
  parameter int WIDTH = ENTRY_W,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     empty_next
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // A pop in the same cycle frees the slot, so a push at full is still taken.
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & (~full | do_pop) & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  assign empty_next = (count_d == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/gpioemu_result_fifo.sv
// Queues multiply/popcount results and serves them to the host through a
// three-register window; tracks dropped results and signals pending data.
module gpioemu_result_fifo
  import gpioemu_pkg::*;
#(
  parameter int          DEPTH     = 8,
  parameter logic [15:0] ADDR_BASE = 16'h03B0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        res_valid,
  input  logic [31:0] res_w,
  input  logic [23:0] res_l,
  input  logic        res_ovf,
  input  logic [15:0] saddress,
  input  logic        srd,
  input  logic        swr,
  input  logic [31:0] sdata_in,
  output logic [31:0] sdata_out,
  output logic        res_pending
);

  localparam int          CW        = $clog2(DEPTH) + 1;
  localparam logic [15:0] ADDR_W    = ADDR_BASE + 16'(OFS_W);
  localparam logic [15:0] ADDR_L    = ADDR_BASE + 16'(OFS_L);
  localparam logic [15:0] ADDR_STAT = ADDR_BASE + 16'(OFS_STAT);

  logic        srd_q, swr_q;
  logic [31:0] sdata_out_q, sdata_out_d;
  logic [7:0]  drop_cnt_q, drop_cnt_d;
  logic        res_pending_q, res_pending_d;

  logic        rd_ev, wr_ev;
  logic        sel_w, sel_l, sel_stat;
  logic        pop, push, flush, clr_drop, drop;
  entry_t      din, head;
  logic [CW-1:0] fifo_count;
  logic        fifo_full, fifo_empty, fifo_empty_next;

  logic unused_sdata_in;
  assign unused_sdata_in = ^{sdata_in[31:2]};

  assign rd_ev    = srd & ~srd_q;
  assign wr_ev    = swr & ~swr_q;
  assign sel_w    = (saddress == ADDR_W);
  assign sel_l    = (saddress == ADDR_L);
  assign sel_stat = (saddress == ADDR_STAT);

  assign pop      = rd_ev & sel_l & ~fifo_empty;
  assign flush    = wr_ev & sel_stat & sdata_in[FLUSH_BIT];
  assign clr_drop = wr_ev & sel_stat & sdata_in[CLR_DROP_BIT];
  assign push     = res_valid & (~fifo_full | pop) & ~flush;
  assign drop     = res_valid & fifo_full & ~pop & ~flush;

  assign din = '{ovf: res_ovf, l: res_l, w: res_w};

  gpioemu_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .pop        (pop),
    .flush      (flush),
    .din        (din),
    .dout       (head),
    .count      (fifo_count),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .empty_next (fifo_empty_next)
  );

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (clr_drop)
      drop_cnt_d = '0;
    else if (drop && drop_cnt_q != 8'hFF)
      drop_cnt_d = drop_cnt_q + 8'd1;
  end

  // Read data is captured only on a read event and held until the next one.
  always_comb begin
    sdata_out_d = sdata_out_q;
    if (rd_ev) begin
      sdata_out_d = '0;
      if (sel_w && !fifo_empty)
        sdata_out_d = head.w;
      else if (sel_l && !fifo_empty)
        sdata_out_d = {7'b0, head.ovf, head.l};
      else if (sel_stat)
        sdata_out_d = pack_status(drop_cnt_q, fifo_full, fifo_empty,
                                  STAT_CNT_W'(fifo_count));
    end
  end

  assign res_pending_d = ~fifo_empty_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      srd_q         <= 1'b0;
      swr_q         <= 1'b0;
      sdata_out_q   <= '0;
      drop_cnt_q    <= '0;
      res_pending_q <= 1'b0;
    end else begin
      srd_q         <= srd;
      swr_q         <= swr;
      sdata_out_q   <= sdata_out_d;
      drop_cnt_q    <= drop_cnt_d;
      res_pending_q <= res_pending_d;
    end
  end

  assign sdata_out   = sdata_out_q;
  assign res_pending = res_pending_q;

endmodule

// File: tb/tb_gpioemu_result_fifo.sv
// Directed bench for gpioemu_result_fifo: push/pop ordering, full/drop,
// coincident push+pop, strobe edge detection, flush/clear and async reset.
module tb_gpioemu_result_fifo;

  localparam logic [15:0] BASE  = 16'h03B0;
  localparam logic [15:0] A_W   = BASE;
  localparam logic [15:0] A_L   = BASE + 16'd8;
  localparam logic [15:0] A_ST  = BASE + 16'd16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        res_valid = 1'b0;
  logic [31:0] res_w = '0;
  logic [23:0] res_l = '0;
  logic        res_ovf = 1'b0;
  logic [15:0] saddress = '0;
  logic        srd = 1'b0;
  logic        swr = 1'b0;
  logic [31:0] sdata_in = '0;
  logic [31:0] sdata_out;
  logic        res_pending;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  gpioemu_result_fifo #(.DEPTH(8), .ADDR_BASE(BASE)) dut (
    .clk         (clk),
    .reset       (reset),
    .res_valid   (res_valid),
    .res_w       (res_w),
    .res_l       (res_l),
    .res_ovf     (res_ovf),
    .saddress    (saddress),
    .srd         (srd),
    .swr         (swr),
    .sdata_in    (sdata_in),
    .sdata_out   (sdata_out),
    .res_pending (res_pending)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic push(input logic [31:0] w, input logic [23:0] l, input logic ovf);
    @(negedge clk);
    res_valid = 1'b1; res_w = w; res_l = l; res_ovf = ovf;
    @(negedge clk);
    res_valid = 1'b0;
  endtask

  task automatic host_read(input logic [15:0] a, output logic [31:0] d);
    @(negedge clk);
    saddress = a; srd = 1'b1;
    @(negedge clk);
    srd = 1'b0;
    d = sdata_out;
  endtask

  task automatic host_write(input logic [15:0] a, input logic [31:0] d);
    @(negedge clk);
    saddress = a; sdata_in = d; swr = 1'b1;
    @(negedge clk);
    swr = 1'b0;
  endtask

  initial begin
    logic [31:0] d;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset_sdata_out", sdata_out, 32'h0);
    chk("reset_pending", {31'b0, res_pending}, 32'h0);
    host_read(A_ST, d);
    chk("reset_status", d, 32'h0000_4000);

    // 1: single entry round trip
    push(32'h0000_1234, 24'd5, 1'b0);
    chk("t1_pending", {31'b0, res_pending}, 32'h1);
    host_read(A_ST, d);  chk("t1_status", d, 32'h0000_0001);
    host_read(A_W, d);   chk("t1_w", d, 32'h0000_1234);
    host_read(A_L, d);   chk("t1_l", d, 32'h0000_0005);
    chk("t1_pending_after", {31'b0, res_pending}, 32'h0);
    host_read(A_ST, d);  chk("t1_status_empty", d, 32'h0000_4000);
    host_read(A_L, d);   chk("t1_l_empty", d, 32'h0);
    host_read(16'h03B4, d); chk("t1_unmapped", d, 32'h0);

    // 2: overfill by one
    for (int i = 0; i < 9; i++) push(32'h100 + i, 24'(i), 1'b0);
    host_read(A_ST, d);  chk("t2_status_full", d, 32'h0100_8008);
    for (int i = 0; i < 8; i++) begin
      host_read(A_W, d); chk($sformatf("t2_w%0d", i), d, 32'h100 + i);
      host_read(A_L, d); chk($sformatf("t2_l%0d", i), d, 32'(i));
    end
    host_read(A_ST, d);  chk("t2_status_empty", d, 32'h0100_4000);

    // 3: push coincident with pop at full
    for (int i = 0; i < 8; i++) push(32'h200 + i, 24'h10 + 24'(i), 1'b0);
    @(negedge clk);
    saddress = A_L; srd = 1'b1;
    res_valid = 1'b1; res_w = 32'h0000_ABCD; res_l = 24'h77; res_ovf = 1'b0;
    @(negedge clk);
    srd = 1'b0; res_valid = 1'b0;
    chk("t3_pop_data", sdata_out, 32'h0000_0010);
    host_read(A_ST, d);  chk("t3_status", d, 32'h0100_8008);
    for (int i = 1; i < 8; i++) begin
      host_read(A_L, d); chk($sformatf("t3_l%0d", i), d, 32'h10 + i);
    end
    host_read(A_W, d);   chk("t3_last_w", d, 32'h0000_ABCD);
    host_read(A_L, d);   chk("t3_last_l", d, 32'h0000_0077);

    // 4: overflow flag and held read strobe
    push(32'h5, 24'h20, 1'b1);
    push(32'h9, 24'h33, 1'b0);
    @(negedge clk);
    saddress = A_L; srd = 1'b1;
    repeat (10) @(negedge clk);
    chk("t4_ovf_l", sdata_out, 32'h0100_0020);
    srd = 1'b0;
    host_read(A_ST, d);  chk("t4_one_pop", d, 32'h0100_0001);
    host_read(A_L, d);   chk("t4_second", d, 32'h0000_0033);

    // 5: flush and clear drop count together
    for (int i = 0; i < 9; i++) push(32'(i), 24'(i), 1'b0);
    for (int i = 0; i < 5; i++) host_read(A_L, d);
    chk("t5_fifth_pop", d, 32'h4);
    host_read(A_ST, d);  chk("t5_status_before", d, 32'h0200_0003);
    host_write(A_ST, 32'h3);
    chk("t5_pending", {31'b0, res_pending}, 32'h0);
    host_read(A_ST, d);  chk("t5_status_after", d, 32'h0000_4000);

    // 6: asynchronous reset mid-stream
    for (int i = 0; i < 5; i++) push(32'h300 + i, 24'(i + 1), 1'b0);
    host_read(A_ST, d);  chk("t6_status", d, 32'h0000_0005);
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_sdata_out", sdata_out, 32'h0);
    chk("t6_rst_pending", {31'b0, res_pending}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    host_read(A_L, d);   chk("t6_l_after", d, 32'h0);
    host_read(A_ST, d);  chk("t6_status_after", d, 32'h0000_4000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
